// File: rtl/mod_wb_arbiter.sv
// mod_wb_arbiter: instruction/data arbiter onto one Wishbone B4 classic master port with wait-state timeout
module mod_wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_D_STREAK   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_req_i,
    input  logic [XLEN-1:0] i_adr_i,
    input  logic            i_abort_i,
    output logic [XLEN-1:0] i_dat_o,
    output logic            i_ack_o,
    output logic            i_err_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic [XLEN-1:0] d_dat_i,
    input  logic [3:0]      d_sel_i,
    output logic [XLEN-1:0] d_dat_o,
    output logic            d_ack_o,
    output logic            d_err_o,
    output logic [XLEN-1:0] wb_adr_o,
    output logic [XLEN-1:0] wb_dat_o,
    output logic [3:0]      wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_stb_o,
    output logic            wb_cyc_o,
    input  logic [XLEN-1:0] wb_dat_i,
    input  logic            wb_ack_i,
    output logic            busy_o
);
    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [3:0]  streak_q;
    logic [15:0] wait_q;
    logic        i_win, gnt_i, gnt_d, tmo, done, i_live;
    assign busy_o = state_q != IDLE;
    // Grant decision, end-of-cycle detection and next state
    always_comb begin
        i_win   = i_req_i && !i_abort_i && (!d_req_i || streak_q == 4'(MAX_D_STREAK));
        gnt_i   = state_q == IDLE && i_win;
        gnt_d   = state_q == IDLE && d_req_i && !i_win;
        tmo     = !wb_ack_i && wait_q == 16'(TIMEOUT_CYCLES - 1);
        done    = state_q != IDLE && (wb_ack_i || tmo);
        i_live  = state_q == BUS_I && !i_abort_i;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_i ? BUS_I : gnt_d ? BUS_D : IDLE;
            BUS_I:   state_d = done ? IDLE : i_abort_i ? DRAIN : BUS_I;
            default: state_d = done ? IDLE : state_q;
        endcase
    end
    // State, starvation counter, wait counter and all registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wait_q   <= '0;
            i_dat_o  <= '0;
            i_ack_o  <= 1'b0;
            i_err_o  <= 1'b0;
            d_dat_o  <= '0;
            d_ack_o  <= 1'b0;
            d_err_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= (!i_req_i || gnt_i) ? '0 :
                        (gnt_d && streak_q < 4'(MAX_D_STREAK)) ? streak_q + 4'd1 : streak_q;
            wait_q   <= (state_q == IDLE || done) ? '0 : wait_q + 16'd1;
            i_ack_o  <= i_live && wb_ack_i;
            i_err_o  <= i_live && tmo;
            d_ack_o  <= state_q == BUS_D && wb_ack_i;
            d_err_o  <= state_q == BUS_D && tmo;
            if (i_live && wb_ack_i)
                i_dat_o <= wb_dat_i;
            if (state_q == BUS_D && wb_ack_i)
                d_dat_o <= wb_dat_i;
            if (gnt_i || gnt_d) begin
                wb_adr_o <= gnt_i ? i_adr_i : d_adr_i;
                wb_dat_o <= gnt_i ? '0 : d_dat_i;
                wb_sel_o <= gnt_i ? 4'hF : d_sel_i;
                wb_we_o  <= gnt_d && d_we_i;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (done) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mod_wb_arbiter.sv
// tb_mod_wb_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mod_wb_arbiter;
    localparam int XLEN = 32;
    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic i_req_i, i_abort_i, d_req_i, d_we_i;
    logic [XLEN-1:0] i_adr_i, d_adr_i, d_dat_i;
    logic [3:0] d_sel_i;
    logic [XLEN-1:0] i_dat_o, d_dat_o, wb_adr_o, wb_dat_o, wb_dat_i;
    logic i_ack_o, i_err_o, d_ack_o, d_err_o;
    logic [3:0] wb_sel_o;
    logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, busy_o;

    mod_wb_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO), .MAX_D_STREAK(MAXS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_abort_i(i_abort_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
        .d_sel_i(d_sel_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave: acks in the (slv_lat+1)-th cycle of a bus cycle when enabled; stray drives a rogue ack
    int slv_cnt = 0;
    int slv_lat = 0;
    logic slv_en = 1'b1;
    logic stray = 1'b0;
    logic [XLEN-1:0] slv_data = '0;
    assign wb_dat_i = slv_data;
    assign wb_ack_i = (wb_cyc_o && wb_stb_o && slv_en && slv_cnt == slv_lat) || stray;
    always @(posedge clk_i) slv_cnt <= wb_cyc_o ? slv_cnt + 1 : 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [XLEN-1:0] a, input logic [XLEN-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model state: owner 0 none, 1 instruction, 2 data, 3 aborted instruction
    int own = 0, waits = 0, streak = 0;
    bit armed = 0;
    logic e_cyc = 0, e_we = 0, e_iack = 0, e_ierr = 0, e_dack = 0, e_derr = 0;
    logic [XLEN-1:0] e_adr = '0, e_wdat = '0, e_idat = '0, e_ddat = '0;
    logic [3:0] e_sel = '0;

    // Monitor bookkeeping used by the literal checks
    int dack_cnt = 0, iack_cnt = 0, derr_cnt = 0, run = 0, last_len = 0;
    logic prev_cyc = 0;
    string order = "";

    // Compare against the model, record history, then advance the model to the next edge
    always @(negedge clk_i) begin
        bit take_i, take_d;
        if (armed) begin
            chk("cyc", wb_cyc_o, e_cyc);
            chk("stb", wb_stb_o, e_cyc);
            chk("busy", busy_o, own != 0);
            chk("i_ack", i_ack_o, e_iack);
            chk("i_err", i_err_o, e_ierr);
            chk("d_ack", d_ack_o, e_dack);
            chk("d_err", d_err_o, e_derr);
            chk("i_dat", i_dat_o, e_idat);
            chk("d_dat", d_dat_o, e_ddat);
            if (e_cyc) begin
                chk("wb_adr", wb_adr_o, e_adr);
                chk("wb_dat", wb_dat_o, e_wdat);
                chk("wb_sel", wb_sel_o, e_sel);
                chk("wb_we", wb_we_o, e_we);
            end
        end
        dack_cnt += d_ack_o;
        iack_cnt += i_ack_o;
        derr_cnt += d_err_o;
        if (wb_cyc_o && !prev_cyc) order = {order, (wb_adr_o[15:12] == 4'h1) ? "I" : "D"};
        if (wb_cyc_o) run++;
        else if (run != 0) begin last_len = run; run = 0; end
        prev_cyc = wb_cyc_o;
        if (!rst_i) begin
            armed = 1; own = 0; waits = 0; streak = 0;
            e_cyc = 0; e_we = 0; e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0;
            e_adr = '0; e_wdat = '0; e_idat = '0; e_ddat = '0; e_sel = '0;
        end else begin
            e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0;
            if (own == 0) begin
                take_i = i_req_i && !i_abort_i && (!d_req_i || streak >= MAXS);
                take_d = d_req_i && !take_i;
                if (take_i) begin
                    own = 1; waits = 0; streak = 0; e_cyc = 1;
                    e_adr = i_adr_i; e_wdat = '0; e_sel = 4'hF; e_we = 0;
                end else if (take_d) begin
                    own = 2; waits = 0; e_cyc = 1;
                    e_adr = d_adr_i; e_wdat = d_dat_i; e_sel = d_sel_i; e_we = d_we_i;
                    if (i_req_i && streak < MAXS) streak++;
                end
            end else if (wb_ack_i) begin
                if (own == 1 && !i_abort_i) begin e_iack = 1; e_idat = wb_dat_i; end
                if (own == 2) begin e_dack = 1; e_ddat = wb_dat_i; end
                own = 0; e_cyc = 0;
            end else begin
                waits++;
                if (waits == TMO) begin
                    if (own == 1 && !i_abort_i) e_ierr = 1;
                    if (own == 2) e_derr = 1;
                    own = 0; e_cyc = 0;
                end else if (own == 1 && i_abort_i) own = 3;
            end
            if (!i_req_i) streak = 0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(input bit instr, input int lim);
        for (int n = 0; n < lim; n++) begin
            step();
            if (instr ? (i_ack_o || i_err_o) : (d_ack_o || d_err_o)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: no completion within %0d cycles", lim);
    endtask

    initial begin
        int nd, base;
        bit seen;
        rst_i = 0; i_req_i = 0; i_abort_i = 0; i_adr_i = '0;
        d_req_i = 0; d_we_i = 0; d_adr_i = '0; d_dat_i = '0; d_sel_i = 4'hF;
        repeat (3) step();
        rst_i = 1;
        step();
        chk("reset_cyc", wb_cyc_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_d_dat", d_dat_o, 0);

        slv_lat = 3; slv_data = 32'hDEADBEEF;
        d_adr_i = 32'h100; d_we_i = 0; d_sel_i = 4'hF; d_req_i = 1;
        wait_done(0, 40);
        d_req_i = 0;
        step(); step();
        chk("load_cyc_len", last_len, 4);
        chk("load_data", d_dat_o, 32'hDEADBEEF);
        chk("load_ack_count", dack_cnt, 1);

        slv_lat = 2; slv_data = 32'h0;
        d_we_i = 1; d_sel_i = 4'b0011; d_dat_i = 32'h0000ABCD; d_adr_i = 32'h200; d_req_i = 1;
        step(); step();
        chk("store_we", wb_we_o, 1);
        chk("store_sel", wb_sel_o, 4'b0011);
        chk("store_dat", wb_dat_o, 32'h0000ABCD);
        wait_done(0, 40);
        d_req_i = 0; d_we_i = 0; d_sel_i = 4'hF;
        step();

        slv_lat = 1; slv_data = 32'h12345678;
        order = ""; nd = 0; seen = 0;
        d_adr_i = 32'h2000; i_adr_i = 32'h1000; d_req_i = 1; i_req_i = 1;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            if (d_ack_o) begin nd++; d_adr_i += 4; end
            if (i_ack_o) begin seen = 1; i_req_i = 0; d_req_i = 0; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL starve: i_ack_o never seen");
        end
        step(); step();
        chk("d_acks_before_i", nd, 4);
        chk("grant_order", order == "DDDDI", 1);
        chk("i_dat", i_dat_o, 32'h12345678);

        base = iack_cnt;
        slv_lat = 3; slv_data = 32'hCAFEF00D;
        i_adr_i = 32'h1100; i_req_i = 1;
        step(); step();
        i_abort_i = 1; i_req_i = 0; d_adr_i = 32'h2100; d_req_i = 1;
        step();
        i_abort_i = 0; order = "";
        wait_done(0, 40);
        d_req_i = 0;
        step(); step();
        chk("abort_no_iack", iack_cnt, base);
        chk("abort_then_d", order == "D", 1);

        slv_lat = 0;
        i_adr_i = 32'h1200; i_req_i = 1; i_abort_i = 1;
        step();
        chk("idle_abort_blocks", wb_cyc_o, 0);
        i_abort_i = 0;
        step();
        chk("idle_abort_release", wb_cyc_o, 1);
        wait_done(1, 20);
        i_req_i = 0;
        step();

        base = dack_cnt;
        slv_lat = 2; d_adr_i = 32'h2200; d_req_i = 1;
        step(); step();
        i_abort_i = 1;
        step();
        i_abort_i = 0;
        wait_done(0, 20);
        d_req_i = 0;
        step(); step();
        chk("bus_d_abort_ignored", dack_cnt, base + 1);

        slv_en = 0; d_adr_i = 32'h300; d_req_i = 1;
        wait_done(0, 50);
        chk("timeout_err", d_err_o, 1);
        d_req_i = 0;
        step(); step();
        chk("timeout_len", last_len, TMO);
        chk("timeout_idle", busy_o, 0);
        chk("timeout_err_count", derr_cnt, 1);
        slv_en = 1;

        base = dack_cnt;
        slv_lat = TMO - 1; d_adr_i = 32'h304; d_req_i = 1;
        wait_done(0, 50);
        d_req_i = 0;
        step(); step();
        chk("ack_beats_timeout", dack_cnt, base + 1);
        chk("ack_beats_timeout_err", derr_cnt, 1);

        base = dack_cnt;
        stray = 1;
        step();
        stray = 0;
        step(); step();
        chk("stray_ack_ignored", dack_cnt, base);
        chk("stray_idle", busy_o, 0);

        base = dack_cnt;
        slv_en = 0; i_adr_i = 32'h1300; d_adr_i = 32'h400; i_req_i = 1; d_req_i = 1;
        step(); step();
        chk("pre_reset_streak", dut.streak_q, 1);
        rst_i = 0; i_req_i = 0; d_req_i = 0;
        step();
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_streak", dut.streak_q, 0);
        rst_i = 1; slv_en = 1;
        step(); step();
        chk("rst_no_ack", dack_cnt, base);
        chk("rst_no_err", derr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
